// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encodings and the default datapath width.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } divState_e;

endpackage

// File: rtl/sub_step.sv
// N-bit subtractor (a - b) built from 4-bit carry-lookahead groups rippled group to group.
// borrow is high when b > a (no carry out of a + ~b + 1).
module sub_step #(
    parameter int unsigned N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int unsigned BLK = 4;
    localparam int unsigned NB  = (N + BLK - 1) / BLK;

    logic [N-1:0] bInv;
    logic [N-1:0] g;
    logic [N-1:0] p;

    assign bInv = ~b;
    assign g    = a & bInv;
    assign p    = a ^ bInv;

    // Per group: each internal carry is a sum of generate/propagate products of the group cin.
    always_comb begin
        logic           cin;
        logic [BLK:0]   bc;
        logic           pr;
        int unsigned    base;
        int unsigned    blkW;
        diff = '0;
        cin  = 1'b1;
        bc   = '0;
        pr   = 1'b0;
        base = 0;
        blkW = 0;
        for (int unsigned blk = 0; blk < NB; blk++) begin
            base  = blk * BLK;
            blkW  = (N - base < BLK) ? (N - base) : BLK;
            bc    = '0;
            bc[0] = cin;
            for (int unsigned k = 0; k < blkW; k++) begin
                for (int unsigned j = 0; j <= k; j++) begin
                    pr = g[base + j];
                    for (int unsigned m = j + 1; m <= k; m++) begin
                        pr = pr & p[base + m];
                    end
                    bc[k + 1] = bc[k + 1] | pr;
                end
                pr = bc[0];
                for (int unsigned m = 0; m <= k; m++) begin
                    pr = pr & p[base + m];
                end
                bc[k + 1] = bc[k + 1] | pr;
            end
            for (int unsigned k = 0; k < blkW; k++) begin
                diff[base + k] = p[base + k] ^ bc[k];
            end
            cin = bc[blkW];
        end
        borrow = ~cin;
    end

endmodule

// File: rtl/seq_divider32.sv
// Iterative restoring divider: one subtract-and-shift step per clock, signed or unsigned,
// behind a start/busy/done handshake.
module seq_divider32
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             isSigned,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);

    localparam int unsigned CW = $clog2(WIDTH);

    divState_e        stateQ, stateD;
    logic [WIDTH:0]   remQ, remD;
    // Holds the dividend magnitude; quotient bits shift in as dividend bits shift out.
    logic [WIDTH-1:0] quoQ, quoD;
    logic [WIDTH-1:0] dsrQ, dsrD;
    logic [CW-1:0]    cntQ, cntD;
    logic             negQuoQ, negQuoD;
    logic             negRemQ, negRemD;
    logic             zeroQ, zeroD;
    logic [WIDTH-1:0] quotientQ, quotientD;
    logic [WIDTH-1:0] remainderQ, remainderD;
    logic             dbzQ, dbzD;
    logic             doneQ, doneD;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             dvdNeg;
    logic             dsrNeg;
    logic             divZero;

    assign dvdNeg  = isSigned & dividend[WIDTH-1];
    assign dsrNeg  = isSigned & divisor[WIDTH-1];
    assign divZero = (divisor == '0);

    // Restored remainder is always below the divisor, so the dropped top bit is zero.
    assign shifted = (remQ << 1) | {{WIDTH{1'b0}}, quoQ[WIDTH-1]};

    sub_step #(
        .N (WIDTH + 1)
    ) uSubStep (
        .a      (shifted),
        .b      ({1'b0, dsrQ}),
        .diff   (trial),
        .borrow (borrow)
    );

    // FSM next-state.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            ST_IDLE:  if (start) stateD = divZero ? ST_FIXUP : ST_CALC;
            ST_CALC:  if (cntQ == CW'(WIDTH - 1)) stateD = ST_FIXUP;
            ST_FIXUP: stateD = ST_IDLE;
            default:  stateD = ST_IDLE;
        endcase
    end

    // Datapath next-state: operand capture, restoring step, sign fixup.
    always_comb begin
        remD       = remQ;
        quoD       = quoQ;
        dsrD       = dsrQ;
        cntD       = cntQ;
        negQuoD    = negQuoQ;
        negRemD    = negRemQ;
        zeroD      = zeroQ;
        quotientD  = quotientQ;
        remainderD = remainderQ;
        dbzD       = dbzQ;
        doneD      = 1'b0;
        unique case (stateQ)
            ST_IDLE: begin
                if (start) begin
                    remD    = '0;
                    cntD    = '0;
                    negQuoD = dvdNeg ^ dsrNeg;
                    negRemD = dvdNeg;
                    zeroD   = divZero;
                    // Divide-by-zero keeps the raw dividend for the remainder output.
                    if (divZero) begin
                        quoD = dividend;
                    end else begin
                        quoD = dvdNeg ? (WIDTH'(0) - dividend) : dividend;
                    end
                    dsrD = dsrNeg ? (WIDTH'(0) - divisor) : divisor;
                end
            end
            ST_CALC: begin
                remD = borrow ? shifted : trial;
                quoD = {quoQ[WIDTH-2:0], ~borrow};
                cntD = cntQ + CW'(1);
            end
            ST_FIXUP: begin
                doneD = 1'b1;
                if (zeroQ) begin
                    quotientD  = '1;
                    remainderD = quoQ;
                    dbzD       = 1'b1;
                end else begin
                    quotientD  = negQuoQ ? (WIDTH'(0) - quoQ) : quoQ;
                    remainderD = negRemQ ? (WIDTH'(0) - remQ[WIDTH-1:0]) : remQ[WIDTH-1:0];
                    dbzD       = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= ST_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remQ       <= '0;
            quoQ       <= '0;
            dsrQ       <= '0;
            cntQ       <= '0;
            negQuoQ    <= 1'b0;
            negRemQ    <= 1'b0;
            zeroQ      <= 1'b0;
            quotientQ  <= '0;
            remainderQ <= '0;
            dbzQ       <= 1'b0;
            doneQ      <= 1'b0;
        end else begin
            remQ       <= remD;
            quoQ       <= quoD;
            dsrQ       <= dsrD;
            cntQ       <= cntD;
            negQuoQ    <= negQuoD;
            negRemQ    <= negRemD;
            zeroQ      <= zeroD;
            quotientQ  <= quotientD;
            remainderQ <= remainderD;
            dbzQ       <= dbzD;
            doneQ      <= doneD;
        end
    end

    assign busy      = (stateQ != ST_IDLE);
    assign done      = doneQ;
    assign quotient  = quotientQ;
    assign remainder = remainderQ;
    assign divByZero = dbzQ;

endmodule
